// File: rtl/clock_pkg.sv
// Shared definitions for the alarm block: FSM encoding, key bit map, set_mode codes, BCD helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package clock_pkg;

  // Alarm controller states
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_RING    = 2'd3
  } alarm_state_t;

  // Bit positions inside key_out (active-low, debounced upstream)
  localparam int KEY_MODE = 0;
  localparam int KEY_INC  = 1;
  localparam int KEY_EN   = 2;
  localparam int KEY_STOP = 3;

  // set_mode output codes
  localparam logic [1:0] MODE_RUN     = 2'b00;
  localparam logic [1:0] MODE_SET_HR  = 2'b01;
  localparam logic [1:0] MODE_SET_MIN = 2'b10;

  // Upper limits of the two-digit BCD alarm fields
  localparam logic [7:0] BCD_HR_MAX  = 8'h23;
  localparam logic [7:0] BCD_MIN_MAX = 8'h59;

  // One-hot-after-priority key events for a single cycle
  typedef struct packed {
    logic mode;
    logic stop;
    logic inc;
    logic en;
  } key_evt_t;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= 4'd9);
  endfunction

  // Two-digit BCD increment with wrap to 00 once 'max' is reached
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    logic [7:0] res;
    if (val == max) begin
      res = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Buzzer driver: TONE_HZ square wave gated 0.5 s on / 0.5 s off, on phase first, while en is high.
// Latency: beep follows en combinationally; first on-phase cycle is the first cycle en is high.
// Backpressure: none; free-running counters held cleared while en is low.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : ring enable (counters restart every time en rises)
//   beep       : gated square-wave output, forced low when en or rst_n is low
module alarm_tone_gen
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TONE_HZ  = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic beep
);

  localparam int HALF_TONE = CLK_FREQ / (2 * TONE_HZ);
  localparam int HALF_SEC  = CLK_FREQ / 2;
  localparam int TW        = $clog2(HALF_TONE + 1);
  localparam int GW        = $clog2(HALF_SEC + 1);

  logic [TW-1:0] tone_cnt;
  logic [GW-1:0] gate_cnt;
  logic          tone_q;
  logic          gate_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt <= '0;
      gate_cnt <= '0;
      tone_q   <= 1'b1;
      gate_on  <= 1'b1;
    end else if (!en) begin
      // Park in the "tone high, gate on" phase so a new ring starts audibly
      tone_cnt <= '0;
      gate_cnt <= '0;
      tone_q   <= 1'b1;
      gate_on  <= 1'b1;
    end else begin
      if (tone_cnt == TW'(HALF_TONE - 1)) begin
        tone_cnt <= '0;
        tone_q   <= ~tone_q;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end

      if (gate_cnt == GW'(HALF_SEC - 1)) begin
        gate_cnt <= '0;
        gate_on  <= ~gate_on;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
      end
    end
  end

  // en is decoded straight from the controller state, so an async reset
  // silences the buzzer without waiting for a clock edge.
  assign beep = en & gate_on & tone_q;

endmodule

// File: rtl/alarm_module.sv
// Alarm controller: key-driven BCD alarm setting, arm toggle, time-match trigger, timed ring, buzzer drive.
// Latency: key press acts on the next clock edge; ringing rises one cycle after the match edge is sampled.
// Backpressure: none; key events are single-cycle pulses, simultaneous presses resolved by fixed priority.
//
// Ports:
//   CLK_50M, RST_N     : system clock, async active-low reset
//   key_out[7:0]       : debounced keys, active-low (0 MODE, 1 INC, 2 EN, 3 STOP; 7:4 unused)
//   hours2..seconds1   : current time, BCD digits
//   alarm_h2..alarm_m1 : stored alarm time, BCD digits
//   alarm_en           : alarm armed
//   set_mode           : 00 run, 01 setting hours, 10 setting minutes
//   ringing            : alarm sounding
//   alarm_beep         : buzzer drive, active-high
module alarm_module
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TONE_HZ  = 2000,
  parameter int RING_SEC = 60
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic [7:0] key_out,
  input  logic [3:0] hours2_data,
  input  logic [3:0] hours1_data,
  input  logic [3:0] minutes2_data,
  input  logic [3:0] minutes1_data,
  input  logic [3:0] seconds2_data,
  input  logic [3:0] seconds1_data,
  output logic [3:0] alarm_h2,
  output logic [3:0] alarm_h1,
  output logic [3:0] alarm_m2,
  output logic [3:0] alarm_m1,
  output logic       alarm_en,
  output logic [1:0] set_mode,
  output logic       ringing,
  output logic       alarm_beep
);

  localparam int PW = $clog2(CLK_FREQ + 1);
  localparam int SW = $clog2(RING_SEC + 1);

  alarm_state_t state, state_nxt;

  logic [7:0]    alarm_hr, alarm_hr_nxt;
  logic [7:0]    alarm_min, alarm_min_nxt;
  logic          armed_q, armed_nxt;

  logic [3:0]    key_q;
  logic          key_live;
  logic [3:0]    press;
  key_evt_t      evt;

  logic          time_bcd;
  logic          match, match_q;
  logic          trigger;

  logic [PW-1:0] presc_cnt;
  logic [SW-1:0] sec_cnt;
  logic          ring_done;

  logic          unused_key_bits;
  assign unused_key_bits = ^key_out[7:4];

  // ---------------------------------------------------------------------------
  // Key edge detect. key_q holds last cycle's level (reset = released). key_live
  // stays low for the first clock after reset so a key held through reset
  // release is captured as the old level rather than reported as a press.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      key_q    <= 4'hF;
      key_live <= 1'b0;
    end else begin
      key_q    <= key_out[3:0];
      key_live <= 1'b1;
    end
  end

  assign press = key_live ? (key_q & ~key_out[3:0]) : 4'h0;

  // Only the highest-priority press of a cycle survives: MODE > STOP > INC > EN
  always_comb begin
    evt      = '0;
    evt.mode = press[KEY_MODE];
    evt.stop = press[KEY_STOP] & ~press[KEY_MODE];
    evt.inc  = press[KEY_INC]  & ~press[KEY_MODE] & ~press[KEY_STOP];
    evt.en   = press[KEY_EN]   & ~press[KEY_MODE] & ~press[KEY_STOP] & ~press[KEY_INC];
  end

  // ---------------------------------------------------------------------------
  // Time match. Non-BCD digits never match. The match level is tracked in every
  // state, so a match that started while setting is not seen as a fresh edge
  // on return to RUN, and a held match cannot re-trigger after a ring ends.
  // ---------------------------------------------------------------------------
  assign time_bcd = is_bcd(hours2_data)   & is_bcd(hours1_data)   &
                    is_bcd(minutes2_data) & is_bcd(minutes1_data) &
                    is_bcd(seconds2_data) & is_bcd(seconds1_data);

  assign match = time_bcd &&
                 ({hours2_data, hours1_data}     == alarm_hr)  &&
                 ({minutes2_data, minutes1_data} == alarm_min) &&
                 ({seconds2_data, seconds1_data} == 8'h00);

  assign trigger = armed_q && (state == ST_RUN) && match && !match_q;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match;
    end
  end

  // ---------------------------------------------------------------------------
  // Ring timer: 1 s prescaler plus seconds count, both held at zero outside
  // RING so they start fresh on every entry.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      presc_cnt <= '0;
      sec_cnt   <= '0;
    end else if (state != ST_RING) begin
      presc_cnt <= '0;
      sec_cnt   <= '0;
    end else if (presc_cnt == PW'(CLK_FREQ - 1)) begin
      presc_cnt <= '0;
      sec_cnt   <= sec_cnt + 1'b1;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  assign ring_done = (state == ST_RING) &&
                     (presc_cnt == PW'(CLK_FREQ - 1)) &&
                     (sec_cnt == SW'(RING_SEC - 1));

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_RUN;
      alarm_hr  <= 8'h00;
      alarm_min <= 8'h00;
      armed_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      alarm_hr  <= alarm_hr_nxt;
      alarm_min <= alarm_min_nxt;
      armed_q   <= armed_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    alarm_hr_nxt  = alarm_hr;
    alarm_min_nxt = alarm_min;
    armed_nxt     = armed_q;
    set_mode      = MODE_RUN;

    case (state)
      ST_RUN: begin
        // A MODE press beats a coincident trigger; an EN press in the
        // trigger cycle is dropped so arming cannot change as the ring starts.
        if (evt.mode) begin
          state_nxt = ST_SET_HR;
        end else if (trigger) begin
          state_nxt = ST_RING;
        end else if (evt.en) begin
          armed_nxt = ~armed_q;
        end
      end

      ST_SET_HR: begin
        set_mode = MODE_SET_HR;
        if (evt.mode) begin
          state_nxt = ST_SET_MIN;
        end else if (evt.inc) begin
          alarm_hr_nxt = bcd_inc(alarm_hr, BCD_HR_MAX);
        end
      end

      ST_SET_MIN: begin
        set_mode = MODE_SET_MIN;
        if (evt.mode) begin
          state_nxt = ST_RUN;
        end else if (evt.inc) begin
          // Minute wrap does not carry into hours
          alarm_min_nxt = bcd_inc(alarm_min, BCD_MIN_MAX);
        end
      end

      ST_RING: begin
        if (evt.mode || evt.stop || ring_done) begin
          state_nxt = ST_RUN;
        end
      end

      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign ringing  = (state == ST_RING);
  assign alarm_en = armed_q;
  assign alarm_h2 = alarm_hr[7:4];
  assign alarm_h1 = alarm_hr[3:0];
  assign alarm_m2 = alarm_min[7:4];
  assign alarm_m1 = alarm_min[3:0];

  alarm_tone_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TONE_HZ  (TONE_HZ)
  ) u_tone (
    .clk   (CLK_50M),
    .rst_n (RST_N),
    .en    (ringing),
    .beep  (alarm_beep)
  );

endmodule
